// File: rtl/galaga_lib.sv
// Shared keyboard definitions: HID keycodes, decoded key set and decoder payload types.
package galaga_lib;

    localparam int unsigned KC_W     = 8;
    localparam int unsigned NUM_KEYS = 7;

    localparam logic [KC_W-1:0] KEY_NONE     = 8'h00;
    localparam logic [KC_W-1:0] ROLLOVER_KEY = 8'h01;
    localparam logic [KC_W-1:0] KEY_A        = 8'h04;
    localparam logic [KC_W-1:0] KEY_D        = 8'h07;
    localparam logic [KC_W-1:0] KEY_R        = 8'h15;
    localparam logic [KC_W-1:0] KEY_S        = 8'h16;
    localparam logic [KC_W-1:0] KEY_W        = 8'h1A;
    localparam logic [KC_W-1:0] KEY_ENTER    = 8'h28;
    localparam logic [KC_W-1:0] KEY_SPACE    = 8'h2C;

    typedef enum logic [2:0] {
        K_W,
        K_A,
        K_S,
        K_D,
        K_SPACE,
        K_ENTER,
        K_R
    } key_idx_t;

    typedef logic [NUM_KEYS-1:0] keyset_t;

    typedef struct packed {
        logic [KC_W-1:0] data;
        logic            last;
    } kc_beat_t;

    typedef enum logic {
        S_SCAN,
        S_COMMIT
    } dec_state_t;

    // One-hot key bit for a game keycode; anything else decodes to the empty set.
    function automatic keyset_t key_decode(input logic [KC_W-1:0] code);
        keyset_t k;
        k = '0;
        case (code)
            KEY_W:     k[K_W]     = 1'b1;
            KEY_A:     k[K_A]     = 1'b1;
            KEY_S:     k[K_S]     = 1'b1;
            KEY_D:     k[K_D]     = 1'b1;
            KEY_SPACE: k[K_SPACE] = 1'b1;
            KEY_ENTER: k[K_ENTER] = 1'b1;
            KEY_R:     k[K_R]     = 1'b1;
            default:   k          = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/galaga_fire_cooldown.sv
// Fire rate limiter: gates SPACE presses through a reload-on-fire cooldown counter.
// Optional repeat-while-held behaviour is enabled by GALAGA_AUTOFIRE_EN.
module galaga_fire_cooldown #(
    parameter int unsigned      CD_W          = 24,
    parameter logic [CD_W-1:0]  FIRE_COOLDOWN = CD_W'(2_500_000)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press,
    input  logic held,
    input  logic tick,
    output logic fire_pulse
);

    logic [CD_W-1:0] cd_q;
    logic            idle_c;
    logic            fire_c;

    assign idle_c = (cd_q == '0);

`ifdef GALAGA_AUTOFIRE_EN
    // A held key re-fires each time the counter drains; a fresh press is always held too.
    assign fire_c = idle_c & (press | held);
`else
    logic unused_held;
    assign unused_held = held;
    assign fire_c      = idle_c & press;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_q       <= '0;
            fire_pulse <= 1'b0;
        end else begin
            fire_pulse <= fire_c;
            if (fire_c) begin
                cd_q <= FIRE_COOLDOWN;
            end else if (tick && !idle_c) begin
                cd_q <= cd_q - CD_W'(1);
            end
        end
    end

endmodule

// File: rtl/galaga_key_decoder.sv
// HID boot-report keycode consumer: collects a report, then commits held directions and press pulses.
// Build option: GALAGA_AUTOFIRE_EN (fire repeats while SPACE is held).
module galaga_key_decoder
    import galaga_lib::*;
#(
    parameter int unsigned     MAX_KEYS      = 6,
    parameter int unsigned     CD_W          = 24,
    parameter logic [CD_W-1:0] FIRE_COOLDOWN = CD_W'(2_500_000)
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            kc_valid,
    output logic            kc_ready,
    input  logic [KC_W-1:0] kc_data,
    input  logic            kc_last,
    output logic            move_up,
    output logic            move_left,
    output logic            move_down,
    output logic            move_right,
    output logic            fire_pulse,
    output logic            start_pulse,
    output logic            restart_pulse,
    output logic            report_err
);

    localparam int unsigned CNT_W = $clog2(MAX_KEYS + 1);

    dec_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    keyset_t           scratch_q, scratch_d;
    keyset_t           held_q, held_d;
    logic              poison_q, poison_d;
    keyset_t           edge_c;
    logic              err_c;
    logic              xfer_c;
    kc_beat_t          beat_c;

    assign beat_c = '{data: kc_data, last: kc_last};
    assign xfer_c = kc_valid & kc_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_SCAN;
            cnt_q     <= '0;
            scratch_q <= '0;
            held_q    <= '0;
            poison_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            held_q    <= held_d;
            poison_q  <= poison_d;
        end
    end

    // Report accumulation in SCAN, single-cycle commit of the held set in COMMIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        held_d    = held_q;
        poison_d  = poison_q;
        edge_c    = '0;
        err_c     = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (xfer_c) begin
                    scratch_d = scratch_q | key_decode(beat_c.data);
                    if (beat_c.data == ROLLOVER_KEY) begin
                        poison_d = 1'b1;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_c.last || (cnt_q == CNT_W'(MAX_KEYS - 1))) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                if (poison_q) begin
                    err_c = 1'b1;
                end else begin
                    held_d = scratch_q;
                    edge_c = scratch_q & ~held_q;
                end
                scratch_d = '0;
                cnt_d     = '0;
                poison_d  = 1'b0;
                state_d   = S_SCAN;
            end
            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    // Outputs follow the next held set so they land the cycle after COMMIT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_ready      <= 1'b1;
            move_up       <= 1'b0;
            move_left     <= 1'b0;
            move_down     <= 1'b0;
            move_right    <= 1'b0;
            start_pulse   <= 1'b0;
            restart_pulse <= 1'b0;
            report_err    <= 1'b0;
        end else begin
            kc_ready      <= (state_d == S_SCAN);
            move_up       <= held_d[K_W] & ~held_d[K_S];
            move_down     <= held_d[K_S] & ~held_d[K_W];
            move_left     <= held_d[K_A] & ~held_d[K_D];
            move_right    <= held_d[K_D] & ~held_d[K_A];
            start_pulse   <= edge_c[K_ENTER];
            restart_pulse <= edge_c[K_R];
            report_err    <= err_c;
        end
    end

    galaga_fire_cooldown #(
        .CD_W          (CD_W),
        .FIRE_COOLDOWN (FIRE_COOLDOWN)
    ) u_fire_cooldown (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .press      (edge_c[K_SPACE]),
        .held       (held_d[K_SPACE]),
        .tick       (1'b1),
        .fire_pulse (fire_pulse)
    );

endmodule

// File: tb/tb_galaga_key_decoder.sv
// Directed bench for galaga_key_decoder with a shortened fire cooldown.
module tb_galaga_key_decoder;

    localparam int unsigned CD = 64;
`ifdef GALAGA_AUTOFIRE_EN
    localparam int HOLD_FIRES = 4;
`else
    localparam int HOLD_FIRES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kc_valid = 1'b0;
    logic       kc_ready;
    logic [7:0] kc_data = 8'h00;
    logic       kc_last = 1'b0;
    logic       move_up, move_left, move_down, move_right;
    logic       fire_pulse, start_pulse, restart_pulse, report_err;

    int n_cmp = 0;
    int n_err = 0;
    int fire_cnt = 0, start_cnt = 0, restart_cnt = 0, err_cnt = 0;
    int f0;

    galaga_key_decoder #(
        .MAX_KEYS      (6),
        .CD_W          (24),
        .FIRE_COOLDOWN (24'(CD))
    ) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .kc_valid      (kc_valid),
        .kc_ready      (kc_ready),
        .kc_data       (kc_data),
        .kc_last       (kc_last),
        .move_up       (move_up),
        .move_left     (move_left),
        .move_down     (move_down),
        .move_right    (move_right),
        .fire_pulse    (fire_pulse),
        .start_pulse   (start_pulse),
        .restart_pulse (restart_pulse),
        .report_err    (report_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fire_pulse)    fire_cnt    <= fire_cnt + 1;
        if (start_pulse)   start_cnt   <= start_cnt + 1;
        if (restart_pulse) restart_cnt <= restart_cnt + 1;
        if (report_err)    err_cnt     <= err_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        kc_valid = 1'b1;
        kc_data  = d;
        kc_last  = l;
        while (!kc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_err++;
            $error("FAIL beat_timeout: observed ready 0 expected ready within 20 cycles");
        end
        @(posedge clk);
        #1;
        kc_valid = 1'b0;
        kc_data  = 8'h00;
        kc_last  = 1'b0;
    endtask

    // Byte 0 of v is sent first; kc_last is raised on the final beat when use_last is set.
    task automatic rpt(input int n, input logic [47:0] v, input logic use_last);
        for (int i = 0; i < n; i++) begin
            beat(v[8*i +: 8], use_last && (i == n - 1));
        end
    endtask

    function automatic logic [7:0] outs();
        return {move_up, move_left, move_down, move_right,
                fire_pulse, start_pulse, restart_pulse, report_err};
    endfunction

    initial begin
        #12;
        check("reset_outputs", 32'(outs()), 0);
        check("reset_ready", 32'(kc_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // W followed by five null bytes
        rpt(6, 48'h00_00_00_00_00_1A, 1'b1);
        check("w_ready_low", 32'(kc_ready), 0);
        check("w_up_commit_cycle", 32'(move_up), 0);
        step();
        check("w_up", 32'(move_up), 1);
        check("w_ready_back", 32'(kc_ready), 1);
        step();
        check("w_no_pulses", 32'(fire_cnt + start_cnt + restart_cnt + err_cnt), 0);

        // W+S cancel, then S alone
        rpt(2, 48'h16_1A, 1'b1);
        step();
        check("ws_up", 32'(move_up), 0);
        check("ws_down", 32'(move_down), 0);
        rpt(1, 48'h16, 1'b1);
        step();
        check("s_down", 32'(move_down), 1);
        check("s_up", 32'(move_up), 0);

        // SPACE press fires once, held SPACE and early re-press do not
        rpt(1, 48'h2C, 1'b1);
        step();
        check("fire_first", 32'(fire_pulse), 1);
        check("fire_down_released", 32'(move_down), 0);
        step();
        check("fire_one_cycle", 32'(fire_pulse), 0);
        check("fire_cnt_1", 32'(fire_cnt), 1);
        repeat (10) step();
        rpt(1, 48'h2C, 1'b1);
        step();
        step();
        check("fire_held_no_refire", 32'(fire_cnt), 1);
        rpt(6, 48'h0, 1'b0);
        check("max_keys_close", 32'(kc_ready), 0);
        step();
        step();
        rpt(1, 48'h2C, 1'b1);
        step();
        step();
        check("fire_cooldown_drop", 32'(fire_cnt), 1);
        rpt(1, 48'h00, 1'b1);
        repeat (CD + 5) step();
        rpt(1, 48'h2C, 1'b1);
        step();
        check("fire_after_cooldown", 32'(fire_pulse), 1);
        step();
        check("fire_cnt_2", 32'(fire_cnt), 2);

        // ENTER press, poisoned report, then ENTER still held with R pressed
        rpt(1, 48'h28, 1'b1);
        step();
        check("start_pulse", 32'(start_pulse), 1);
        step();
        check("start_cnt_1", 32'(start_cnt), 1);
        rpt(2, 48'h15_01, 1'b1);
        step();
        check("rollover_err", 32'(report_err), 1);
        step();
        check("rollover_err_one_cycle", 32'(report_err), 0);
        check("rollover_no_restart", 32'(restart_cnt), 0);
        check("rollover_err_cnt", 32'(err_cnt), 1);
        rpt(2, 48'h15_28, 1'b1);
        step();
        check("restart_pulse", 32'(restart_pulse), 1);
        step();
        check("enter_still_held", 32'(start_cnt), 1);
        check("restart_cnt_1", 32'(restart_cnt), 1);
        rpt(1, 48'h15, 1'b1);
        step();
        step();
        check("restart_held_no_pulse", 32'(restart_cnt), 1);

        // A+D cancel; duplicate A is just A
        rpt(2, 48'h07_04, 1'b1);
        step();
        check("ad_left", 32'(move_left), 0);
        check("ad_right", 32'(move_right), 0);
        rpt(2, 48'h04_04, 1'b1);
        step();
        check("aa_left", 32'(move_left), 1);
        check("aa_right", 32'(move_right), 0);

        // Reset in the middle of a report drops the partial scratch set
        beat(8'h04, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'(outs()), 0);
        check("midrst_ready", 32'(kc_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rpt(1, 48'h07, 1'b1);
        step();
        check("fresh_right", 32'(move_right), 1);
        check("fresh_left", 32'(move_left), 0);

        // SPACE held for several cooldown periods, then released
        repeat (CD + 5) step();
        f0 = fire_cnt;
        rpt(1, 48'h2C, 1'b1);
        repeat (3 * (CD + 1) + 20) step();
        check("space_hold_fires", 32'(fire_cnt - f0), 32'(HOLD_FIRES));
        rpt(1, 48'h00, 1'b1);
        repeat (2 * (CD + 1)) step();
        check("space_release_stops", 32'(fire_cnt - f0), 32'(HOLD_FIRES));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
